// File: rtl/i2c_pkg.sv
// Shared types for the I2C boot-time configuration sequencer.
//   seq_state_t : sequencer FSM states
//   cfg_entry_t : one configuration table entry {addr[15:0], data[7:0]}
//   DLY_MARKER  : register address that marks a delay entry (data = ticks)
package i2c_pkg;

  localparam logic [15:0] DLY_MARKER = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DLY,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_GAP,
    ST_FAIL,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } seq_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

endpackage

// File: rtl/i2c_cfg_timer.sv
// Loadable down-counter with a zero flag. One instance is time-shared by the
// inter-transaction gap, delay entries and the RW_Done watchdog; only one of
// those is ever active, so a single load port suffices.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : counter is at zero (it stops there)
module i2c_cfg_timer #(
  parameter int W = 24
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Boot-time configuration engine: walks a ROM table of {addr16, data8}
// entries and issues one i2c_control write per entry, with optional
// read-back verification, delay entries, NACK retries and a watchdog.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   start               : 1-cycle pulse, runs the table from entry 0
//   tbl_idx / tbl_data  : synchronous ROM port (data valid 1 cycle later)
//   wrreg_req/rdreg_req : 1-cycle request pulses to i2c_control
//   addr, wrdata        : register address / write data of current entry
//   addr_mode,device_id : static configuration for i2c_control
//   rddata, RW_Done, ack: transaction result (ack=1 means NACK seen)
//   busy, done, error   : status; done/error are sticky until next start
//   err_idx             : index of the entry that caused the abort
module i2c_cfg_sequencer
  import i2c_pkg::*;
#(
  parameter int          N_ENTRIES   = 64,
  parameter int          IDX_W       = 6,
  parameter logic [7:0]  DEV_ID      = 8'h78,
  parameter int          ADDR_MODE   = 1,
  parameter int          VERIFY      = 0,
  parameter int          MAX_RETRY   = 3,
  parameter int          GAP_CYC     = 100,
  parameter int          DLY_UNIT    = 50000,
  parameter int          TIMEOUT_CYC = 2000000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [23:0]      tbl_data,
  output logic             wrreg_req,
  output logic             rdreg_req,
  output logic [15:0]      addr,
  output logic             addr_mode,
  output logic [7:0]       wrdata,
  output logic [7:0]       device_id,
  input  logic [7:0]       rddata,
  input  logic             RW_Done,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  // Timer must hold the largest of: gap, longest delay entry, watchdog.
  localparam int unsigned DLY_MAX = 255 * DLY_UNIT;
  localparam int unsigned LD_A    = (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int unsigned LD_MAX  = (LD_A > DLY_MAX) ? LD_A : DLY_MAX;
  localparam int          TW      = $clog2(LD_MAX + 1);
  localparam int          RET_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // A load of N keeps the timer busy for N+1 cycles, hence the -1.
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] DLY_U  = TW'(DLY_UNIT);

  seq_state_t       state, state_nxt, tgt, tgt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt, err_idx_nxt;
  logic [RET_W-1:0] retry, retry_nxt;
  cfg_entry_t       ent, ent_nxt;
  logic             busy_nxt, done_nxt, error_nxt;
  logic             go_err;
  logic             tmr_load, tmr_zero;
  logic [TW-1:0]    tmr_val;

  i2c_cfg_timer #(.W(TW)) u_timer (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      tgt     <= ST_IDLE;
      idx     <= '0;
      retry   <= '0;
      ent     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      err_idx <= '0;
    end else begin
      state   <= state_nxt;
      tgt     <= tgt_nxt;
      idx     <= idx_nxt;
      retry   <= retry_nxt;
      ent     <= ent_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      error   <= error_nxt;
      err_idx <= err_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tgt_nxt     = tgt;
    idx_nxt     = idx;
    retry_nxt   = retry;
    ent_nxt     = ent;
    busy_nxt    = busy;
    done_nxt    = done;
    error_nxt   = error;
    err_idx_nxt = err_idx;
    go_err      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          done_nxt    = 1'b0;
          error_nxt   = 1'b0;
          err_idx_nxt = '0;
          idx_nxt     = '0;
          retry_nxt   = '0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_FETCH;
        end
      end

      ST_FETCH: state_nxt = ST_LATCH;

      ST_LATCH: begin
        ent_nxt = cfg_entry_t'(tbl_data);
        if (tbl_data[23:8] == DLY_MARKER) begin
          if (tbl_data[7:0] == 8'd0) begin
            state_nxt = ST_NEXT;
          end else begin
            tmr_load  = 1'b1;
            tmr_val   = TW'(tbl_data[7:0]) * DLY_U - TW'(1);
            state_nxt = ST_DLY;
          end
        end else begin
          state_nxt = ST_WR_REQ;
        end
      end

      ST_DLY: if (tmr_zero) state_nxt = ST_NEXT;

      // The watchdog is armed in the request cycle so it starts fresh on
      // the first WAIT cycle.
      ST_WR_REQ: begin
        tmr_load  = 1'b1;
        tmr_val   = TO_LD;
        state_nxt = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (RW_Done) begin
          if (ack) begin
            state_nxt = ST_FAIL;
          end else begin
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
            tgt_nxt   = (VERIFY != 0) ? ST_RD_REQ : ST_NEXT;
            state_nxt = ST_GAP;
          end
        end else if (tmr_zero) begin
          go_err = 1'b1;
        end
      end

      ST_RD_REQ: begin
        tmr_load  = 1'b1;
        tmr_val   = TO_LD;
        state_nxt = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (RW_Done) begin
          if (ack || (rddata != ent.data)) begin
            state_nxt = ST_FAIL;
          end else begin
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
            tgt_nxt   = ST_NEXT;
            state_nxt = ST_GAP;
          end
        end else if (tmr_zero) begin
          go_err = 1'b1;
        end
      end

      ST_GAP: if (tmr_zero) state_nxt = tgt;

      ST_FAIL: begin
        if (retry < RET_W'(MAX_RETRY)) begin
          retry_nxt = retry + RET_W'(1);
          tmr_load  = 1'b1;
          tmr_val   = GAP_LD;
          tgt_nxt   = ST_WR_REQ;
          state_nxt = ST_GAP;
        end else begin
          go_err = 1'b1;
        end
      end

      ST_NEXT: begin
        retry_nxt = '0;
        if (idx == IDX_W'(N_ENTRIES - 1)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = ST_FETCH;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (go_err) begin
      error_nxt   = 1'b1;
      err_idx_nxt = idx;
      busy_nxt    = 1'b0;
      state_nxt   = ST_ERR;
    end
  end

  assign tbl_idx   = idx;
  assign wrreg_req = (state == ST_WR_REQ);
  assign rdreg_req = (state == ST_RD_REQ);
  assign addr      = ent.addr;
  assign wrdata    = ent.data;
  assign addr_mode = (ADDR_MODE != 0);
  assign device_id = DEV_ID;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
module tb_i2c_cfg_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: no verify; instance V: read-back verify.
  logic        start_a = 1'b0, start_v = 1'b0;
  logic [1:0]  a_idx, v_idx, a_eidx, v_eidx;
  logic [23:0] a_tbl = '0, v_tbl = '0;
  logic        a_wr, a_rd, v_wr, v_rd, a_mode, v_mode;
  logic [15:0] a_addr, v_addr;
  logic [7:0]  a_wd, v_wd, a_dev, v_dev;
  logic        a_busy, a_done, a_err, v_busy, v_done, v_err;

  logic        rw_done = 1'b0, ack_m = 1'b0;
  logic [7:0]  rd_m = '0;

  logic [23:0] rom [4];
  bit          sel = 1'b0;
  bit          mute = 1'b0;
  logic [15:0] nack_addr = '0, bad_addr = '0;
  int          nack_limit = 0;

  int total = 0;
  int bad = 0;

  i2c_cfg_sequencer #(.N_ENTRIES(4), .IDX_W(2), .VERIFY(0), .MAX_RETRY(3),
    .GAP_CYC(8), .DLY_UNIT(10), .TIMEOUT_CYC(500)) u_a (
    .Clk(clk), .Rst_n(rst_n), .start(start_a), .tbl_idx(a_idx), .tbl_data(a_tbl),
    .wrreg_req(a_wr), .rdreg_req(a_rd), .addr(a_addr), .addr_mode(a_mode),
    .wrdata(a_wd), .device_id(a_dev), .rddata(rd_m), .RW_Done(rw_done), .ack(ack_m),
    .busy(a_busy), .done(a_done), .error(a_err), .err_idx(a_eidx));

  i2c_cfg_sequencer #(.N_ENTRIES(4), .IDX_W(2), .VERIFY(1), .MAX_RETRY(3),
    .GAP_CYC(8), .DLY_UNIT(10), .TIMEOUT_CYC(500)) u_v (
    .Clk(clk), .Rst_n(rst_n), .start(start_v), .tbl_idx(v_idx), .tbl_data(v_tbl),
    .wrreg_req(v_wr), .rdreg_req(v_rd), .addr(v_addr), .addr_mode(v_mode),
    .wrdata(v_wd), .device_id(v_dev), .rddata(rd_m), .RW_Done(rw_done), .ack(ack_m),
    .busy(v_busy), .done(v_done), .error(v_err), .err_idx(v_eidx));

  always @(posedge clk) begin
    a_tbl <= rom[a_idx];
    v_tbl <= rom[v_idx];
  end

  logic        s_wr, s_rd, s_busy, s_done, s_err, s_start;
  logic [15:0] s_addr;
  logic [7:0]  s_wd;
  logic [1:0]  s_eidx, s_idx;
  assign s_wr    = sel ? v_wr   : a_wr;
  assign s_rd    = sel ? v_rd   : a_rd;
  assign s_busy  = sel ? v_busy : a_busy;
  assign s_done  = sel ? v_done : a_done;
  assign s_err   = sel ? v_err  : a_err;
  assign s_eidx  = sel ? v_eidx : a_eidx;
  assign s_idx   = sel ? v_idx  : a_idx;
  assign s_addr  = sel ? v_addr : a_addr;
  assign s_wd    = sel ? v_wd   : a_wd;
  assign s_start = sel ? start_v : start_a;

  // i2c_control model: answers every request 4 cycles later unless muted.
  bit          pend = 1'b0, pend_rd = 1'b0;
  int          lat = 0, nack_given = 0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  always @(posedge clk) begin
    rw_done <= 1'b0;
    ack_m   <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
      nack_given <= 0;
    end else if (s_wr || s_rd) begin
      pend <= 1'b1; pend_rd <= s_rd; lat <= 3; m_addr <= s_addr; m_data <= s_wd;
    end else if (pend && !mute) begin
      if (lat == 0) begin
        pend <= 1'b0;
        rw_done <= 1'b1;
        if (!pend_rd && m_addr == nack_addr && nack_given < nack_limit) begin
          ack_m <= 1'b1;
          nack_given <= nack_given + 1;
        end
        rd_m <= (m_addr == bad_addr) ? (m_data ^ 8'h01) : m_data;
      end else begin
        lat <= lat - 1;
      end
    end
  end

  // Request monitor: records every request of the selected instance.
  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, last_t = -1000, min_gap = 1000000;
  bit          both = 1'b0;
  logic [15:0] wr_addr [16];
  logic [7:0]  wr_data [16];
  int          wr_t [16];
  logic [15:0] rd_addr [16];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n || (s_start && !s_busy)) begin
      wr_cnt <= 0; rd_cnt <= 0; last_t <= -1000; min_gap <= 1000000; both <= 1'b0;
    end else begin
      if (s_wr && s_rd) both <= 1'b1;
      if (s_wr && wr_cnt < 16) begin
        wr_addr[wr_cnt] <= s_addr; wr_data[wr_cnt] <= s_wd; wr_t[wr_cnt] <= cyc;
        wr_cnt <= wr_cnt + 1;
      end
      if (s_rd && rd_cnt < 16) begin
        rd_addr[rd_cnt] <= s_addr;
        rd_cnt <= rd_cnt + 1;
      end
      if (s_wr || s_rd) begin
        if ((cyc - last_t) < min_gap) min_gap <= cyc - last_t;
        last_t <= cyc;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start_a = 1'b0; start_v = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    if (sel) start_v = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_v = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (s_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic load_basic();
    rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'h4300_30; rom[3] = 24'hFFFF_00;
  endtask

  logic [15:0] ea [3];
  logic [7:0]  ed [3];

  task automatic test_reset();
    sel = 0;
    do_reset();
    total++;
    if ({a_busy, a_done, a_err, a_eidx, a_wr, a_rd, a_idx, a_addr, a_wd} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b eidx=%0d wr=%b rd=%b idx=%0d addr=%h wd=%h, want all 0",
               a_busy, a_done, a_err, a_eidx, a_wr, a_rd, a_idx, a_addr, a_wd);
    end
    total++;
    if (a_dev !== 8'h78) begin bad++; $display("FAIL device_id: got %h want 78", a_dev); end
    total++;
    if (a_mode !== 1'b1) begin bad++; $display("FAIL addr_mode: got %b want 1", a_mode); end
  endtask

  task automatic test_basic();
    int k;
    sel = 0; nack_limit = 0; mute = 0; bad_addr = '0;
    load_basic();
    ea = '{16'h3008, 16'h3103, 16'h4300};
    ed = '{8'h82, 8'h03, 8'h30};
    do_reset();
    pulse_start();
    wait_idle(400);
    total++;
    if (a_busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", a_busy); end
    total++;
    if (wr_cnt != 3) begin bad++; $display("FAIL basic_wr_cnt: got %0d want 3", wr_cnt); end
    for (k = 0; k < 3; k++) begin
      total++;
      if (wr_addr[k] !== ea[k] || wr_data[k] !== ed[k]) begin
        bad++;
        $display("FAIL basic_entry%0d: got %h/%h want %h/%h", k, wr_addr[k], wr_data[k], ea[k], ed[k]);
      end
    end
    total++;
    if (min_gap < 9) begin bad++; $display("FAIL basic_spacing: got %0d want >=9", min_gap); end
    total++;
    if ({a_done, a_err} !== 2'b10) begin bad++; $display("FAIL basic_status: got done=%b err=%b want 1/0", a_done, a_err); end
    total++;
    if (rd_cnt != 0) begin bad++; $display("FAIL basic_rd_cnt: got %0d want 0", rd_cnt); end
  endtask

  task automatic test_retry();
    int n3103 = 0;
    sel = 0; nack_addr = 16'h3103; nack_limit = 2;
    load_basic();
    do_reset();
    pulse_start();
    wait_idle(600);
    for (int k = 0; k < wr_cnt && k < 16; k++) if (wr_addr[k] == 16'h3103) n3103++;
    total++;
    if (wr_cnt != 5) begin bad++; $display("FAIL retry_wr_cnt: got %0d want 5", wr_cnt); end
    total++;
    if (n3103 != 3) begin bad++; $display("FAIL retry_attempts: got %0d want 3", n3103); end
    total++;
    if (wr_addr[4] !== 16'h4300) begin bad++; $display("FAIL retry_last_addr: got %h want 4300", wr_addr[4]); end
    total++;
    if ({a_busy, a_done, a_err} !== 3'b010) begin
      bad++; $display("FAIL retry_status: got busy=%b done=%b err=%b want 0/1/0", a_busy, a_done, a_err);
    end
  endtask

  task automatic test_nack_fail();
    int n4300 = 0, n5000 = 0;
    sel = 0; nack_addr = 16'h4300; nack_limit = 100;
    rom[0] = 24'h3008_82; rom[1] = 24'h3103_03; rom[2] = 24'h4300_30; rom[3] = 24'h5000_11;
    do_reset();
    pulse_start();
    wait_idle(800);
    for (int k = 0; k < wr_cnt && k < 16; k++) begin
      if (wr_addr[k] == 16'h4300) n4300++;
      if (wr_addr[k] == 16'h5000) n5000++;
    end
    total++;
    if (wr_cnt != 6) begin bad++; $display("FAIL nack_wr_cnt: got %0d want 6", wr_cnt); end
    total++;
    if (n4300 != 4) begin bad++; $display("FAIL nack_attempts: got %0d want 4", n4300); end
    total++;
    if (n5000 != 0) begin bad++; $display("FAIL nack_entry3_req: got %0d want 0", n5000); end
    total++;
    if ({a_busy, a_done, a_err, a_eidx} !== 5'b00110) begin
      bad++; $display("FAIL nack_status: got busy=%b done=%b err=%b eidx=%0d want 0/0/1/2", a_busy, a_done, a_err, a_eidx);
    end
  endtask

  task automatic test_restart();
    sel = 0; nack_limit = 0;
    pulse_start();
    total++;
    if ({a_busy, a_err, a_eidx, a_done} !== 5'b10000) begin
      bad++; $display("FAIL restart_clear: got busy=%b err=%b eidx=%0d done=%b want 1/0/0/0", a_busy, a_err, a_eidx, a_done);
    end
    wait_idle(600);
    total++;
    if (wr_cnt != 4 || wr_addr[3] !== 16'h5000) begin
      bad++; $display("FAIL restart_writes: got cnt=%0d last=%h want 4/5000", wr_cnt, wr_addr[3]);
    end
    total++;
    if ({a_done, a_err} !== 2'b10) begin bad++; $display("FAIL restart_status: got done=%b err=%b want 1/0", a_done, a_err); end
  endtask

  task automatic test_verify();
    sel = 1; nack_limit = 0; bad_addr = 16'h4300;
    load_basic();
    do_reset();
    pulse_start();
    wait_idle(1000);
    total++;
    if (wr_cnt != 6 || rd_cnt != 6) begin bad++; $display("FAIL verify_counts: got wr=%0d rd=%0d want 6/6", wr_cnt, rd_cnt); end
    total++;
    if (rd_addr[0] !== 16'h3008) begin bad++; $display("FAIL verify_rd_addr: got %h want 3008", rd_addr[0]); end
    total++;
    if (both !== 1'b0 || min_gap < 9) begin bad++; $display("FAIL verify_req_spacing: got both=%b gap=%0d want 0/>=9", both, min_gap); end
    total++;
    if ({v_busy, v_done, v_err, v_eidx} !== 5'b00110) begin
      bad++; $display("FAIL verify_status: got busy=%b done=%b err=%b eidx=%0d want 0/0/1/2", v_busy, v_done, v_err, v_eidx);
    end
    bad_addr = '0;
    sel = 0;
  endtask

  task automatic test_delay();
    int d;
    sel = 0; nack_limit = 0;
    rom[0] = 24'h3008_82; rom[1] = 24'hFFFF_02; rom[2] = 24'h4300_30; rom[3] = 24'hFFFF_00;
    do_reset();
    pulse_start();
    wait_idle(600);
    d = wr_t[1] - wr_t[0];
    total++;
    if (wr_cnt != 2 || wr_addr[1] !== 16'h4300) begin
      bad++; $display("FAIL delay_writes: got cnt=%0d addr1=%h want 2/4300", wr_cnt, wr_addr[1]);
    end
    total++;
    if (d < 29 || d > 45) begin bad++; $display("FAIL delay_spacing: got %0d want 29..45", d); end
    total++;
    if (a_done !== 1'b1) begin bad++; $display("FAIL delay_done: got %b want 1", a_done); end
  endtask

  task automatic test_timeout();
    int n = 0, t_err;
    sel = 0; mute = 1;
    load_basic();
    do_reset();
    pulse_start();
    while (wr_cnt == 0 && n < 50) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    pulse_start();
    total++;
    if (a_busy !== 1'b1 || a_idx !== 2'd0 || wr_cnt != 1) begin
      bad++; $display("FAIL busy_start_ignored: got busy=%b idx=%0d wr=%0d want 1/0/1", a_busy, a_idx, wr_cnt);
    end
    n = 0;
    while (!a_err && n < 1000) begin @(negedge clk); n++; end
    t_err = cyc - wr_t[0];
    total++;
    if (t_err < 498 || t_err > 505) begin bad++; $display("FAIL timeout_latency: got %0d want 498..505", t_err); end
    total++;
    if ({a_busy, a_done, a_err, a_eidx} !== 5'b00100 || wr_cnt != 1) begin
      bad++; $display("FAIL timeout_status: got busy=%b done=%b err=%b eidx=%0d wr=%0d want 0/0/1/0/1",
                      a_busy, a_done, a_err, a_eidx, wr_cnt);
    end
    mute = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sel = 0; mute = 0;
    load_basic();
    do_reset();
    pulse_start();
    while (wr_cnt == 0 && n < 50) begin @(negedge clk); n++; end
    total++;
    if (a_busy !== 1'b1 || wr_cnt != 1) begin bad++; $display("FAIL midreset_pre: got busy=%b wr=%0d want 1/1", a_busy, wr_cnt); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({a_busy, a_done, a_err, a_eidx, a_wr, a_rd, a_idx, a_addr, a_wd} !== '0) begin
      bad++; $display("FAIL midreset_async: got busy=%b addr=%h wd=%h want all 0", a_busy, a_addr, a_wd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || wr_cnt != 0) begin bad++; $display("FAIL midreset_idle: got busy=%b wr=%0d want 0/0", a_busy, wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_nack_fail();
    test_restart();
    test_verify();
    test_delay();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, limit 2000000");
    $fatal(1);
  end

endmodule
